// File: rtl/rob_ar_scheduler_pkg.sv
// Shared ID/depth definitions for the reorder-buffer front end.
// Pure typedefs and constants: no latency, no flow control.
package reorder_pkg;
  localparam int ID_WIDTH  = 4;
  localparam int ROB_DEPTH = 2**ID_WIDTH;
  typedef logic [ID_WIDTH-1:0] id_t;
endpackage

// File: rtl/rob_ar_scheduler_arb.sv
// Round-robin arbiter: one-hot grant from req, search starts at the held pointer.
// Grant is combinational; the pointer moves past the winner only when adv is high.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         adv,
  output logic [N-1:0] gnt
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW:0]   sum;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(i);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        if (adv) ptr_d = (idx == PW'(N-1)) ? '0 : idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
endmodule

// File: rtl/rob_ar_scheduler.sv
// Shares one ROB among NUM_REQ AXI readers: RR-arbitrated AR (1-cycle to m_arvalid), R routed back with 0 latency.
// AR slot holds under m_arready_i=0; grants stall on in-flight IDs or a full ROB; R stalls on the head requester's RREADY.
module rob_ar_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ROB_DEPTH  = reorder_pkg::ROB_DEPTH
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ*reorder_pkg::ID_WIDTH-1:0] s_arid_i,
  input  logic [NUM_REQ-1:0]                   s_arvalid_i,
  output logic [NUM_REQ-1:0]                   s_arready_o,
  output logic [DATA_WIDTH-1:0]                s_rdata_o,
  output logic [reorder_pkg::ID_WIDTH-1:0]     s_rid_o,
  output logic [NUM_REQ-1:0]                   s_rvalid_o,
  input  logic [NUM_REQ-1:0]                   s_rready_i,
  output logic [reorder_pkg::ID_WIDTH-1:0]     m_arid_o,
  output logic                                 m_arvalid_o,
  input  logic                                 m_arready_i,
  input  logic [DATA_WIDTH-1:0]                m_rdata_i,
  input  logic [reorder_pkg::ID_WIDTH-1:0]     m_rid_i,
  input  logic                                 m_rvalid_i,
  output logic                                 m_rready_o,
  output logic                                 err_o
);
  import reorder_pkg::*;

  localparam int SW = $clog2(NUM_REQ);
  localparam int PW = $clog2(ROB_DEPTH);
  localparam int CW = PW + 1;

  // run_q keeps every ARREADY low while reset is asserted and for the first cycle after it.
  logic                 run_q, run_d;
  logic                 slot_vld_q, slot_vld_d;
  id_t                  slot_id_q, slot_id_d;
  logic [SW-1:0]        slot_src_q, slot_src_d;
  logic [ROB_DEPTH-1:0] inflight_q, inflight_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [SW-1:0]        fifo_q [ROB_DEPTH];
  logic [SW-1:0]        fifo_d [ROB_DEPTH];
  logic [PW:0]          wptr_q, wptr_d, rptr_q, rptr_d;
  logic                 err_q, err_d;

  logic                 slot_can_load, grant_vld, ar_hs, r_hs, fifo_empty;
  logic [NUM_REQ-1:0]   elig, gnt;
  logic [SW-1:0]        grant_idx, head;
  id_t                  grant_id;

  assign slot_can_load = run_q && (!slot_vld_q || m_arready_i);

  always_comb begin
    elig      = '0;
    grant_idx = '0;
    grant_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      elig[k] = s_arvalid_i[k] && !inflight_q[s_arid_i[k*ID_WIDTH +: ID_WIDTH]]
                && (cnt_q < CW'(ROB_DEPTH));
      if (gnt[k]) begin
        grant_idx = SW'(k);
        grant_id  = s_arid_i[k*ID_WIDTH +: ID_WIDTH];
      end
    end
  end

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (elig),
    .adv   (slot_can_load),
    .gnt   (gnt)
  );

  assign s_arready_o = gnt & {NUM_REQ{slot_can_load}};
  assign grant_vld   = slot_can_load && (|gnt);
  assign ar_hs       = slot_vld_q && m_arready_i;
  assign fifo_empty  = (wptr_q == rptr_q);
  assign head        = fifo_q[rptr_q[PW-1:0]];

  always_comb begin
    s_rvalid_o       = '0;
    s_rvalid_o[head] = m_rvalid_i && !fifo_empty;
  end

  assign m_rready_o  = !fifo_empty && s_rready_i[head];
  assign r_hs        = m_rvalid_i && m_rready_o;
  assign s_rdata_o   = m_rdata_i;
  assign s_rid_o     = m_rid_i;
  assign m_arvalid_o = slot_vld_q;
  assign m_arid_o    = slot_id_q;
  assign err_o       = err_q;

  always_comb begin
    run_d      = 1'b1;
    slot_vld_d = slot_vld_q;
    slot_id_d  = slot_id_q;
    slot_src_d = slot_src_q;
    if (slot_can_load) begin
      slot_vld_d = grant_vld;
      if (grant_vld) begin
        slot_id_d  = grant_id;
        slot_src_d = grant_idx;
      end
    end
    // Tracking starts at grant time so a duplicate ID is blocked while the slot waits.
    inflight_d = inflight_q;
    if (r_hs)      inflight_d[m_rid_i]  = 1'b0;
    if (grant_vld) inflight_d[grant_id] = 1'b1;
    cnt_d  = cnt_q + CW'(grant_vld) - CW'(r_hs);
    fifo_d = fifo_q;
    wptr_d = wptr_q;
    if (ar_hs) begin
      fifo_d[wptr_q[PW-1:0]] = slot_src_q;
      wptr_d                 = wptr_q + 1'b1;
    end
    rptr_d = r_hs ? rptr_q + 1'b1 : rptr_q;
    err_d  = err_q || (m_rvalid_i && (fifo_empty || !inflight_q[m_rid_i]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      slot_vld_q <= 1'b0;
      slot_id_q  <= '0;
      slot_src_q <= '0;
      inflight_q <= '0;
      cnt_q      <= '0;
      fifo_q     <= '{default: '0};
      wptr_q     <= '0;
      rptr_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      run_q      <= run_d;
      slot_vld_q <= slot_vld_d;
      slot_id_q  <= slot_id_d;
      slot_src_q <= slot_src_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      fifo_q     <= fifo_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      err_q      <= err_d;
    end
  end
endmodule
